// File: rtl/overlap_add_engine.sv
// Overlap-add synthesis: accumulates FRAME_LEN-sample frames at HOP stride, paces results out every OUTPUT_RATE clocks. OLA_SATURATE_EN clamps sums instead of wrapping.
// Latency: 2 clocks from input accept to output FIFO push; FIFO head leaves on the next pace tick.
// Backpressure: in_ready drops while FIFO occupancy plus in-flight pushes reaches FIFO_DEPTH, so nothing is dropped.
module overlap_add_engine #(
    parameter int DATA_W      = 12,
    parameter int FRAME_LEN   = 2048,
    parameter int HOP         = 1024,
    parameter int OUTPUT_RATE = 2267,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     underrun,
    output logic                     frame_err
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int PW = (OUTPUT_RATE > 1) ? $clog2(OUTPUT_RATE) : 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] HOP_A    = AW'(HOP);
    localparam logic [PW-1:0] PACE_MAX = PW'(OUTPUT_RATE - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t state, state_nxt;

    logic [AW-1:0] clr_addr;
    logic [AW-1:0] base_ptr;
    logic [AW-1:0] idx;
    logic [AW-1:0] rd_addr;
    logic          accept;
    logic          idx_last;

    logic signed [DATA_W-1:0] acc_mem [FRAME_LEN];

    logic                     s1_vld;
    logic                     s1_final;
    logic [AW-1:0]            s1_addr;
    logic signed [DATA_W-1:0] s1_data;
    logic signed [DATA_W-1:0] s1_acc;
    logic signed [DATA_W-1:0] sum;

    logic                     s2_vld;
    logic signed [DATA_W-1:0] s2_dat;

    logic signed [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]            wr_ptr;
    logic [FW-1:0]            rd_ptr;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [1:0]               inflight;
    logic [CW-1:0]            occupancy;

    logic [PW-1:0] pace_cnt;
    logic          pace_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_addr == LAST_IDX) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == S_CLEAR) begin
            clr_addr <= clr_addr + AW'(1);
        end
    end

    assign accept   = in_valid & in_ready;
    assign idx_last = (idx == LAST_IDX);
    assign rd_addr  = base_ptr + idx;

    // A frame closes on in_last or on the last index, whichever comes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            base_ptr  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept & (in_last ^ idx_last);
            if (accept) begin
                if (in_last || idx_last) begin
                    idx      <= '0;
                    base_ptr <= base_ptr + HOP_A;
                end else begin
                    idx <= idx + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr  <= rd_addr;
            s1_data  <= in_data;
            s1_acc   <= acc_mem[rd_addr];
            s1_final <= (idx < HOP_A);
        end
    end

`ifdef OLA_SATURATE_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0] sum_wide;

    assign sum_wide = {s1_acc[DATA_W-1], s1_acc} + {s1_data[DATA_W-1], s1_data};

    // Differing top two bits of the widened sum mean the result left the DATA_W range.
    always_comb begin
        sum = sum_wide[DATA_W-1:0];
        if (sum_wide[DATA_W] != sum_wide[DATA_W-1]) begin
            sum = sum_wide[DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    // Low DATA_W bits of the widened sum equal a native two's-complement add.
    assign sum = s1_acc + s1_data;
`endif

    // Finished samples leave a zero behind so the slot is ready for the next overlap.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            acc_mem[clr_addr] <= '0;
        end else if (s1_vld) begin
            acc_mem[s1_addr] <= s1_final ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld & s1_final;
        end
    end

    always_ff @(posedge clk) begin
        s2_dat <= sum;
    end

    assign push       = s2_vld;
    assign fifo_empty = (fifo_count == '0);
    assign pace_tick  = (pace_cnt == PACE_MAX);
    assign pop        = pace_tick & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FW'(1);
            if (pop)  rd_ptr <= rd_ptr + FW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= s2_dat;
        end
    end

    assign inflight  = {1'b0, s1_vld & s1_final} + {1'b0, s2_vld};
    assign occupancy = fifo_count + CW'(inflight);
    assign in_ready  = (state == S_RUN) && (occupancy < DEPTH_C);

    // Pace counter free-runs through CLEAR too, so the DAC sees a steady cadence.
    always_ff @(posedge clk) begin
        if (rst) begin
            pace_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            underrun  <= 1'b0;
        end else begin
            out_valid <= pace_tick;
            pace_cnt  <= pace_tick ? '0 : pace_cnt + PW'(1);
            if (pace_tick) begin
                out_data <= fifo_empty ? '0 : fifo_mem[rd_ptr];
                if (fifo_empty) underrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/overlap_add_engine.md
Name: overlap_add_engine

Overview:
- Parametrised overlap-add synthesis stage for the output path. Accepts time-domain IFFT frames of FRAME_LEN samples, with a configurable hop (overlap factor FRAME_LEN/HOP).
- Accumulates overlapping frames in an internal circular buffer and queues finished samples in an output FIFO. The FIFO is drained at a fixed pace of one sample per OUTPUT_RATE clocks toward the DAC interface.
- Adds over the previous generation: backpressure, arbitrary overlap factor, a post-reset clear sweep, frame-error and underrun flags.

Parameters:
- DATA_W, 12: signed sample width, input and output.
- FRAME_LEN, 2048: samples per frame. Power of 2, >= 8.
- HOP, 1024: samples per hop. Power of 2, divides FRAME_LEN, 1 < FRAME_LEN/HOP <= 8.
- OUTPUT_RATE, 2267: clocks per output sample (pace period).
- FIFO_DEPTH, 16: output FIFO entries. Power of 2, >= 4.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- in_data, in, DATA_W: signed IFFT sample.
- in_valid, in, 1: in_data valid.
- in_last, in, 1: marks final sample of frame.
- in_ready, out, 1: block accepts a sample when in_valid & in_ready.
- out_data, out, DATA_W: paced output sample.
- out_valid, out, 1: one-cycle strobe per pace tick.
- underrun, out, 1: sticky; pace tick found the FIFO empty.
- frame_err, out, 1: one-cycle pulse when in_last does not coincide with sample index FRAME_LEN-1.

Behaviour:
- Reset values:
  - Outputs: out_data=0, out_valid=0, in_ready=0, underrun=0, frame_err=0.
  - Internal: FIFO empty, pace counter=0, base pointer=0, sample index=0.
- FSM CLEAR:
  - Entered on reset. Writes 0 to accumulator addresses 0..FRAME_LEN-1, one per cycle.
  - in_ready=0 throughout. After FRAME_LEN cycles, transition to RUN.
  - rst asserted mid-operation, in any state, restarts CLEAR from address 0 and empties the FIFO.
- FSM RUN, accepted-sample handling:
  - Sample index i counts accepted samples. Accumulator address = (base + i) mod FRAME_LEN.
  - Cycle 0: read acc[addr]. Cycle 1: sum = acc[addr] + in_data, using the arithmetic below.
  - If i < HOP: sum is final. Push sum to the FIFO and write 0 to acc[addr].
  - Otherwise: write sum back to acc[addr].
  - Pipeline latency is 2 clocks from accept to FIFO push.
  - No read/write hazard handling is required. Same-address accesses are always >= HOP cycles apart.
- Frame boundary:
  - On accepted in_last, or on accept at i=FRAME_LEN-1: i <- 0 and base <- (base + HOP) mod FRAME_LEN.
  - frame_err pulses, one cycle after the accept, if exactly one of (in_last, i==FRAME_LEN-1) is true.
- Backpressure:
  - in_ready = RUN & (fifo_count + pipeline_pushes_in_flight < FIFO_DEPTH).
  - The FIFO therefore never overflows and no sample is dropped.
- Pacing:
  - Free-running counter runs 0..OUTPUT_RATE-1 and wraps. The tick occurs at OUTPUT_RATE-1.
  - On a tick with the FIFO non-empty: pop, and register out_data=head with out_valid=1 for one cycle.
  - On a tick with the FIFO empty: out_valid=1, out_data=0, underrun<-1.
  - out_data holds its value between ticks. The pace counter also runs during CLEAR.
  - A tick during CLEAR finds the FIFO empty, produces a zero output and sets underrun.
- Simultaneous FIFO push and pop in the same cycle: both occur and the count is unchanged. A pop of the last entry coinciding with a push is legal.
- Arithmetic:
  - Signed DATA_W + DATA_W add, computed at DATA_W+1 bits.
  - Result reduced to DATA_W per OLA_SATURATE_EN.
  - No scaling. Window gain normalisation is done upstream.

Optional Feature:
- Macro OLA_SATURATE_EN.
- Defined: the sum is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: the sum wraps, keeping the low DATA_W bits (two's complement).

Test Plan:
- Common bench parameters: FRAME_LEN=8, HOP=4, OUTPUT_RATE=3, FIFO_DEPTH=4, DATA_W=12.
- Reset then idle: in_ready=0 for 8 cycles, then 1. Ticks every 3 clocks give out_valid with out_data=0 and underrun=1.
- Two frames of constant 100, in_last on index 7:
  - Outputs: 100,100,100,100, then 200,200,200,200.
  - frame_err never asserted. Accumulator addresses of the first hop read 0 afterwards.
- Stall: in_valid held high continuously. in_ready drops once FIFO occupancy reaches 4. Output sequence equals the unstalled case with no missing sample.
- in_last on index 5: frame_err pulses once. The next frame starts at base=4 and index 0.
- Overflow, two frames of 2047 with HOP region overlap:
  - With OLA_SATURATE_EN: output 2047.
  - Without OLA_SATURATE_EN: output -2 (wrap).
- rst pulsed mid-frame after 3 samples: FIFO emptied, CLEAR re-runs for 8 cycles, in_ready=0. The next frame's first-hop outputs equal the input samples only (no stale accumulation).
